// File: rtl/mem_access_master.sv
// mem_access_master: initiator side of the data-memory req/ack interface.
// Takes one load/store from the M stage, issues a word-aligned bus request,
// positions store data and byte enables, and extends load data on return.
// Optional build macro MEM_ACCESS_TIMEOUT_EN adds a REQ-phase timeout abort.
module mem_access_master #(
    parameter int unsigned ADDR_W = 32
`ifdef MEM_ACCESS_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ls_start,
    input  logic              ls_we,
    input  logic [2:0]        ls_op,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic              ls_busy,
    output logic              ls_done,
    output logic [31:0]       ls_rdata,
    output logic              ls_exc,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    localparam logic [2:0] OP_W  = 3'd0;
    localparam logic [2:0] OP_B  = 3'd1;
    localparam logic [2:0] OP_BU = 3'd2;
    localparam logic [2:0] OP_H  = 3'd3;
    localparam logic [2:0] OP_HU = 3'd4;

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] cnt, cnt_nx;
`endif

    state_t            state, state_nx;
    logic [2:0]        op_q, op_nx;
    logic              we_q, we_nx;
    logic [1:0]        lane_q, lane_nx;
    logic              done_nx, busy_nx, exc_nx, req_nx, bus_we_nx;
    logic [31:0]       rdata_nx, wdata_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic [3:0]        be_nx;
    logic              illegal_c;
    logic [3:0]        be_c;
    logic [31:0]       wdata_c;

    // Select and extend the addressed lane of a returned read word
    function automatic logic [31:0] extract_lane(input logic [2:0] op, input logic [1:0] a,
                                                 input logic [31:0] w);
        logic [31:0] sh;
        sh = w >> {a, 3'b000};
        case (op)
            OP_B:    extract_lane = {{24{sh[7]}}, sh[7:0]};
            OP_BU:   extract_lane = {24'd0, sh[7:0]};
            OP_H:    extract_lane = {{16{sh[15]}}, sh[15:0]};
            OP_HU:   extract_lane = {16'd0, sh[15:0]};
            default: extract_lane = w;
        endcase
    endfunction

    // Legality, byte enables and lane-replicated store data for the incoming request
    always_comb begin
        illegal_c = (ls_op > OP_HU)
                  || (ls_we && (ls_op == OP_BU || ls_op == OP_HU))
                  || (ls_op == OP_W && ls_addr[1:0] != 2'b00)
                  || ((ls_op == OP_H || ls_op == OP_HU) && ls_addr[0]);
        case (ls_op)
            OP_B, OP_BU: begin
                be_c    = 4'b0001 << ls_addr[1:0];
                wdata_c = {4{ls_wdata[7:0]}};
            end
            OP_H, OP_HU: begin
                be_c    = ls_addr[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{ls_wdata[15:0]}};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = ls_wdata;
            end
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        state_nx = state;
        op_nx    = op_q;
        we_nx    = we_q;
        lane_nx  = lane_q;
        exc_nx   = ls_exc;
        rdata_nx = ls_rdata;
        addr_nx  = bus_addr;
        be_nx    = bus_be;
        wdata_nx = bus_wdata;
`ifdef MEM_ACCESS_TIMEOUT_EN
        cnt_nx   = cnt;
`endif
        case (state)
            S_IDLE: begin
                if (ls_start) begin
                    op_nx    = ls_op;
                    we_nx    = ls_we;
                    lane_nx  = ls_addr[1:0];
                    rdata_nx = '0;
`ifdef MEM_ACCESS_TIMEOUT_EN
                    cnt_nx   = '0;
`endif
                    if (illegal_c) begin
                        state_nx = S_DONE;
                        exc_nx   = 1'b1;
                    end else begin
                        state_nx = S_REQ;
                        exc_nx   = 1'b0;
                        addr_nx  = {ls_addr[ADDR_W-1:2], 2'b00};
                        be_nx    = be_c;
                        wdata_nx = wdata_c;
                    end
                end
            end
            S_REQ: begin
                if (bus_ack) begin
                    state_nx = S_DONE;
                    rdata_nx = we_q ? 32'd0 : extract_lane(op_q, lane_q, bus_rdata);
                end
`ifdef MEM_ACCESS_TIMEOUT_EN
                else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_nx = S_DONE;
                    exc_nx   = 1'b1;
                    rdata_nx = '0;
                end else begin
                    cnt_nx = CNT_W'(cnt + 1'b1);
                end
`endif
            end
            default: state_nx = S_IDLE;
        endcase
        req_nx    = (state_nx == S_REQ);
        bus_we_nx = req_nx && we_nx;
        busy_nx   = (state_nx != S_IDLE);
        done_nx   = (state_nx == S_DONE);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            op_q      <= '0;
            we_q      <= 1'b0;
            lane_q    <= '0;
            ls_busy   <= 1'b0;
            ls_done   <= 1'b0;
            ls_exc    <= 1'b0;
            ls_rdata  <= '0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
`ifdef MEM_ACCESS_TIMEOUT_EN
            cnt       <= '0;
`endif
        end else begin
            state     <= state_nx;
            op_q      <= op_nx;
            we_q      <= we_nx;
            lane_q    <= lane_nx;
            ls_busy   <= busy_nx;
            ls_done   <= done_nx;
            ls_exc    <= exc_nx;
            ls_rdata  <= rdata_nx;
            bus_req   <= req_nx;
            bus_we    <= bus_we_nx;
            bus_addr  <= addr_nx;
            bus_be    <= be_nx;
            bus_wdata <= wdata_nx;
`ifdef MEM_ACCESS_TIMEOUT_EN
            cnt       <= cnt_nx;
`endif
        end
    end

endmodule

// File: tb/tb_mem_access_master.sv
// Self-checking bench for mem_access_master: random and directed accesses
// against a byte-lane reference model; timeout test when MEM_ACCESS_TIMEOUT_EN.
module tb_mem_access_master;

    localparam int unsigned ADDR_W = 32;
`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam int MAX_DELAY = 2;
`else
    localparam int MAX_DELAY = 6;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        ls_start, ls_we, bus_ack;
    logic [2:0]  ls_op;
    logic [31:0] ls_addr, ls_wdata, bus_rdata;
    logic        ls_busy, ls_done, ls_exc, bus_req, bus_we;
    logic [31:0] ls_rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_be;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_access_master #(
        .ADDR_W(ADDR_W)
`ifdef MEM_ACCESS_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(4)
`endif
    ) dut (
        .clk(clk), .reset(reset),
        .ls_start(ls_start), .ls_we(ls_we), .ls_op(ls_op), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_busy(ls_busy), .ls_done(ls_done), .ls_rdata(ls_rdata),
        .ls_exc(ls_exc), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    // ---------------- reference model ----------------
    function automatic int ref_size(input logic [2:0] op);
        if (op == 3'd0) return 4;
        if (op == 3'd1 || op == 3'd2) return 1;
        return 2;
    endfunction

    function automatic bit ref_legal(input logic [2:0] op, input logic we, input logic [31:0] addr);
        if (op > 3'd4) return 0;
        if (we && (op == 3'd2 || op == 3'd4)) return 0;
        return (int'(addr[1:0]) % ref_size(op)) == 0;
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] op, input logic [31:0] addr);
        logic [3:0] be;
        int a;
        a  = int'(addr[1:0]);
        be = '0;
        for (int i = 0; i < 4; i++)
            if (i >= a && i < a + ref_size(op)) be[i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] op, input logic [31:0] wd);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++)
            r = r | (((wd >> (8 * (i % ref_size(op)))) & 32'hFF) << (8 * i));
        return r;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] addr,
                                             input logic [31:0] word);
        logic [31:0] mask, lane;
        int sz;
        sz   = ref_size(op);
        mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
        lane = (word >> (8 * int'(addr[1:0]))) & mask;
        if ((op == 3'd1 || op == 3'd3) && lane[8 * sz - 1]) lane = lane | ~mask;
        return lane;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one full access and checks every phase against the model
    task automatic run_access(input logic [2:0] op, input logic we, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [31:0] rd, input int delay,
                              input logic start_at_ack);
        logic [31:0] exp_addr, exp_wd, exp_rd;
        logic [3:0]  exp_be;
        bit          legal;
        legal    = ref_legal(op, we, addr);
        exp_addr = addr & ~32'h3;
        exp_be   = ref_be(op, addr);
        exp_wd   = ref_wdata(op, wd);
        ls_start = 1'b1; ls_op = op; ls_we = we; ls_addr = addr; ls_wdata = wd;
        step();
        ls_start = 1'b0; ls_op = 3'($urandom); ls_we = 1'($urandom);
        ls_addr = $urandom; ls_wdata = $urandom;
        if (!legal) begin
            checks++;
            if ({bus_req, ls_done, ls_exc, ls_busy} !== 4'b0111) begin
                failures++;
                $display("FAIL illegal_done op=%0d addr=%h got req/done/exc/busy=%b want 0111",
                         op, addr, {bus_req, ls_done, ls_exc, ls_busy});
            end
            step();
            checks++;
            if ({bus_req, ls_done, ls_busy} !== 3'b000) begin
                failures++;
                $display("FAIL illegal_idle got req/done/busy=%b want 000", {bus_req, ls_done, ls_busy});
            end
            return;
        end
        for (int c = 0; c <= delay; c++) begin
            checks++;
            if (bus_req !== 1'b1 || bus_we !== we || bus_addr !== exp_addr || bus_be !== exp_be ||
                ls_busy !== 1'b1 || ls_done !== 1'b0 || (we && bus_wdata !== exp_wd)) begin
                failures++;
                $display("FAIL req_fields cyc=%0d got req=%b we=%b addr=%h be=%b wd=%h busy=%b done=%b want 1 %b %h %b %h 1 0",
                         c, bus_req, bus_we, bus_addr, bus_be, bus_wdata, ls_busy, ls_done,
                         we, exp_addr, exp_be, exp_wd);
            end
            if (c == delay) begin
                bus_ack = 1'b1; bus_rdata = rd; ls_start = start_at_ack;
            end else begin
                bus_ack = 1'b0; bus_rdata = $urandom; ls_start = 1'($urandom);
            end
            step();
        end
        bus_ack = 1'b0; ls_start = 1'b0; bus_rdata = $urandom;
        exp_rd = we ? 32'd0 : ref_load(op, addr, rd);
        checks++;
        if ({bus_req, ls_done, ls_exc, ls_busy} !== 4'b0101 || ls_rdata !== exp_rd) begin
            failures++;
            $display("FAIL done_pulse op=%0d addr=%h got req/done/exc/busy=%b rdata=%h want 0101 %h",
                     op, addr, {bus_req, ls_done, ls_exc, ls_busy}, ls_rdata, exp_rd);
        end
        step();
        checks++;
        if ({bus_req, ls_done, ls_busy} !== 3'b000 || ls_rdata !== exp_rd) begin
            failures++;
            $display("FAIL done_hold got req/done/busy=%b rdata=%h want 000 %h",
                     {bus_req, ls_done, ls_busy}, ls_rdata, exp_rd);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ls_start = 1'($urandom); ls_we = 1'($urandom); ls_op = 3'($urandom);
            ls_addr = $urandom; ls_wdata = $urandom; bus_ack = 1'($urandom); bus_rdata = $urandom;
            step();
            checks++;
            if ({bus_req, bus_we, ls_busy, ls_done, ls_exc, bus_addr, bus_be, bus_wdata, ls_rdata} !== '0) begin
                failures++;
                $display("FAIL reset_outputs got req=%b we=%b busy=%b done=%b exc=%b addr=%h be=%b wd=%h rd=%h want all 0",
                         bus_req, bus_we, ls_busy, ls_done, ls_exc, bus_addr, bus_be, bus_wdata, ls_rdata);
            end
        end
        ls_start = 1'b0; bus_ack = 1'b0;
        reset = 1'b1;
        step();
        run_access(3'd0, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1, 1'b0);
    endtask

    task automatic test_loads();
        run_access(3'd1, 1'b0, 32'h13, 32'h0, 32'h8012_3456, 0, 1'b0);
        run_access(3'd2, 1'b0, 32'h13, 32'h0, 32'h8012_3456, 2, 1'b0);
        run_access(3'd4, 1'b0, 32'h12, 32'h0, 32'h8001_ABCD, 1, 1'b0);
        run_access(3'd3, 1'b0, 32'h12, 32'h0, 32'h8001_ABCD, 0, 1'b0);
    endtask

    task automatic test_stores();
        run_access(3'd1, 1'b1, 32'h21, 32'h0000_00A5, 32'h0, 1, 1'b0);
        run_access(3'd3, 1'b1, 32'h22, 32'h0000_1234, 32'h0, 0, 1'b0);
        run_access(3'd0, 1'b1, 32'h24, 32'hCAFE_F00D, 32'h0, 2, 1'b0);
    endtask

    task automatic test_illegal();
        run_access(3'd0, 1'b0, 32'h02, 32'h0, 32'h0, 0, 1'b0);
        run_access(3'd3, 1'b1, 32'h01, 32'h0, 32'h0, 0, 1'b0);
        run_access(3'd6, 1'b0, 32'h00, 32'h0, 32'h0, 0, 1'b0);
        run_access(3'd2, 1'b1, 32'h00, 32'h0, 32'h0, 0, 1'b0);
    endtask

    task automatic test_stall_reset();
        int n;
        n = (MAX_DELAY < 4) ? MAX_DELAY : 4;
        run_access(3'd0, 1'b1, 32'h100, 32'h1357_9BDF, 32'h0, n, 1'b0);
        ls_start = 1'b1; ls_op = 3'd0; ls_we = 1'b0; ls_addr = 32'h200;
        step();
        ls_start = 1'b0;
        step();
        step();
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({bus_req, ls_busy, ls_done} !== 3'b000) begin
            failures++;
            $display("FAIL reset_abort got req/busy/done=%b want 000", {bus_req, ls_busy, ls_done});
        end
        #1 reset = 1'b1;
        bus_ack = 1'b1; bus_rdata = $urandom;
        for (int i = 0; i < 4; i++) begin
            step();
            bus_ack = 1'b0;
            checks++;
            if ({bus_req, ls_done} !== 2'b00) begin
                failures++;
                $display("FAIL abort_quiet cyc=%0d got req/done=%b want 00", i, {bus_req, ls_done});
            end
        end
    endtask

    task automatic test_back_to_back();
        run_access(3'd0, 1'b0, 32'h40, 32'h0, 32'h1111_2222, 0, 1'b1);
        run_access(3'd2, 1'b0, 32'h41, 32'h0, 32'hA1B2_C3D4, 0, 1'b1);
        run_access(3'd1, 1'b1, 32'h43, 32'h0000_0077, 32'h0, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 150; i++)
            run_access(3'($urandom_range(0, 5)), 1'($urandom), $urandom, $urandom, $urandom,
                       $urandom_range(0, MAX_DELAY), 1'($urandom));
    endtask

`ifdef MEM_ACCESS_TIMEOUT_EN
    task automatic test_timeout();
        int req_cycles, guard;
        ls_start = 1'b1; ls_op = 3'd0; ls_we = 1'b0; ls_addr = 32'h80;
        step();
        ls_start = 1'b0;
        req_cycles = 0; guard = 0;
        while (ls_done !== 1'b1 && guard < 20) begin
            if (bus_req === 1'b1) req_cycles++;
            guard++;
            step();
        end
        checks++;
        if (ls_done !== 1'b1 || req_cycles != 4 || ls_exc !== 1'b1 || ls_rdata !== 32'd0) begin
            failures++;
            $display("FAIL timeout got done=%b req_cycles=%0d exc=%b rdata=%h want 1 4 1 0",
                     ls_done, req_cycles, ls_exc, ls_rdata);
        end
        step();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; ls_start = 1'b0; ls_we = 1'b0; ls_op = '0;
        ls_addr = '0; ls_wdata = '0; bus_ack = 1'b0; bus_rdata = '0;
        test_reset();
        test_loads();
        test_stores();
        test_illegal();
        test_stall_reset();
        test_back_to_back();
`ifdef MEM_ACCESS_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
